// File: rtl/solver_run_monitor.sv
// solver_run_monitor: per-channel completion monitor for N_CH solver instances.
// It measures completion cycles, latches results, raises error/timeout flags and
// then streams one report beat per channel over a valid/ready handshake.
// Optional feature macro: EXPECTED_CHECK_EN adds ChExpected/AnyMismatch and
// reports a mismatching ok-beat with status 3.
module solver_run_monitor #(
    parameter int  N_CH           = 2,
    parameter int  RES_W          = 64,
    parameter int  CYC_W          = 32,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [N_CH-1:0]       ChDone,
    input  logic [N_CH-1:0]       ChError,
    input  logic [N_CH*RES_W-1:0] ChResult,
`ifdef EXPECTED_CHECK_EN
    input  logic [N_CH*RES_W-1:0] ChExpected,
    output logic                  AnyMismatch,
`endif
    output logic                  Running,
    output logic                  AllDone,
    output logic                  AnyError,
    output logic                  Timeout,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [CH_W-1:0]       OutChannel,
    output logic [RES_W-1:0]      OutResult,
    output logic [CYC_W-1:0]      OutCycles,
    output logic [1:0]            OutStatus,
    output logic                  ReportDone
);

    // state    | meaning
    // IDLE     | waiting for Start after reset
    // RUN      | counting cycles, latching per-channel events
    // REPORT   | streaming one beat per channel, ascending index
    // FINISHED | report complete, flags and latches held
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_REPORT   = 2'd2;
    localparam logic [1:0] S_FINISHED = 2'd3;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic [1:0]       state;
    logic [CYC_W-1:0] cyc;
    logic [N_CH-1:0]  lat_done;
    logic [N_CH-1:0]  lat_err;
    logic [RES_W-1:0] lat_res [N_CH];
    logic [CYC_W-1:0] lat_cyc [N_CH];
    logic [CH_W-1:0]  rpt_idx;

    logic [N_CH-1:0]  ev;
    logic [N_CH-1:0]  nxt_done;
    logic [N_CH-1:0]  nxt_err;
    logic             exit_all;
    logic             exit_err;
    logic             exit_to;
    logic             run_exit;
    logic             beat_accept;
    logic             restart;
    logic [1:0]       beat_status;
    logic [RES_W-1:0] beat_res;
    logic [CYC_W-1:0] beat_cyc;

    // Watchdog compare; a zero limit removes it entirely.
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdog
            assign exit_to = (64'(cyc) == 64'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wdog
            assign exit_to = 1'b0;
        end
    endgenerate

    // First event per channel and the exit decision use the post-latch view,
    // so the run ends in the cycle right after the deciding event.
    always_comb begin
        ev       = ~(lat_done | lat_err) & (ChDone | ChError);
        nxt_done = lat_done | (ev & ChDone);
        nxt_err  = lat_err | (ev & ChError);
        exit_all = &(nxt_done | nxt_err);
        exit_err = |nxt_err;
        run_exit = exit_all | exit_err | exit_to;
    end

    // Beat contents for the channel currently being reported.
    always_comb begin
        beat_status = 2'd2;
        beat_res    = '0;
        beat_cyc    = cyc;
        if (lat_done[rpt_idx] | lat_err[rpt_idx]) begin
            beat_res    = lat_res[rpt_idx];
            beat_cyc    = lat_cyc[rpt_idx];
            beat_status = lat_err[rpt_idx] ? 2'd1 : 2'd0;
        end
`ifdef EXPECTED_CHECK_EN
        if ((beat_status == 2'd0) &&
            (beat_res != ChExpected[int'(rpt_idx)*RES_W +: RES_W]))
            beat_status = 2'd3;
`endif
    end

    assign Running     = (state == S_RUN);
    assign OutValid    = (state == S_REPORT);
    assign OutChannel  = OutValid ? rpt_idx : '0;
    assign OutResult   = OutValid ? beat_res : '0;
    assign OutCycles   = OutValid ? beat_cyc : '0;
    assign OutStatus   = OutValid ? beat_status : 2'd0;
    assign beat_accept = OutValid & OutReady;
    assign restart     = Start & ((state == S_IDLE) | (state == S_FINISHED));

    // Control FSM, cycle counter, event flags and sticky status flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            cyc        <= '0;
            rpt_idx    <= '0;
            lat_done   <= '0;
            lat_err    <= '0;
            AllDone    <= 1'b0;
            AnyError   <= 1'b0;
            Timeout    <= 1'b0;
            ReportDone <= 1'b0;
`ifdef EXPECTED_CHECK_EN
            AnyMismatch <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_FINISHED: begin
                    if (Start) begin
                        state      <= S_RUN;
                        cyc        <= '0;
                        rpt_idx    <= '0;
                        lat_done   <= '0;
                        lat_err    <= '0;
                        AllDone    <= 1'b0;
                        AnyError   <= 1'b0;
                        Timeout    <= 1'b0;
                        ReportDone <= 1'b0;
`ifdef EXPECTED_CHECK_EN
                        AnyMismatch <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    lat_done <= nxt_done;
                    lat_err  <= nxt_err;
                    if (run_exit) begin
                        // cyc is frozen here so unlatched beats report the exit cycle
                        state    <= S_REPORT;
                        AllDone  <= exit_all & (&nxt_done);
                        AnyError <= exit_err;
                        Timeout  <= exit_to;
                    end else if (cyc != '1) begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (beat_accept) begin
`ifdef EXPECTED_CHECK_EN
                        if (beat_status == 2'd3) AnyMismatch <= 1'b1;
`endif
                        if (rpt_idx == LAST_CH) begin
                            state      <= S_FINISHED;
                            ReportDone <= 1'b1;
                        end else begin
                            rpt_idx <= rpt_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-channel result and completion-cycle latches.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (Rst || restart) begin
                lat_res[i] <= '0;
                lat_cyc[i] <= '0;
            end else if ((state == S_RUN) && ev[i]) begin
                lat_res[i] <= ChResult[i*RES_W +: RES_W];
                lat_cyc[i] <= cyc;
            end
        end
    end

endmodule

// File: tb/tb_solver_run_monitor.sv
// Bench for solver_run_monitor: directed scenarios plus randomized runs, each
// predicted from per-channel event times (earliest exit rule) by a small model.
module tb_solver_run_monitor;
    localparam int N_CH  = 2;
    localparam int RES_W = 64;
    localparam int CYC_W = 32;
    localparam int TO    = 20;

    logic                  Clk = 1'b0;
    logic                  Rst = 1'b1;
    logic                  Start = 1'b0;
    logic [N_CH-1:0]       ChDone = '0;
    logic [N_CH-1:0]       ChError = '0;
    logic [N_CH*RES_W-1:0] ChResult = '0;
    logic                  Running, AllDone, AnyError, Timeout, OutValid, ReportDone;
    logic                  OutReady = 1'b0;
    logic [0:0]            OutChannel;
    logic [RES_W-1:0]      OutResult;
    logic [CYC_W-1:0]      OutCycles;
    logic [1:0]            OutStatus;
`ifdef EXPECTED_CHECK_EN
    logic [N_CH*RES_W-1:0] ChExpected = '0;
    logic                  AnyMismatch;
    logic [RES_W-1:0]      exp_v [N_CH];
`endif

    solver_run_monitor #(
        .N_CH(N_CH), .RES_W(RES_W), .CYC_W(CYC_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ChDone(ChDone), .ChError(ChError),
        .ChResult(ChResult),
`ifdef EXPECTED_CHECK_EN
        .ChExpected(ChExpected), .AnyMismatch(AnyMismatch),
`endif
        .Running(Running), .AllDone(AllDone), .AnyError(AnyError), .Timeout(Timeout),
        .OutValid(OutValid), .OutReady(OutReady), .OutChannel(OutChannel),
        .OutResult(OutResult), .OutCycles(OutCycles), .OutStatus(OutStatus),
        .ReportDone(ReportDone)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario description: event cycle per channel (-1 = never), event kind,
    // a late error level after a done-only event, and the result presented.
    int               ev_cyc   [N_CH];
    bit               ev_done  [N_CH];
    bit               ev_err   [N_CH];
    bit               late_err [N_CH];
    logic [RES_W-1:0] res_v    [N_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [RES_W-1:0] rnd_res();
        return {$urandom(), $urandom()};
    endfunction

    task automatic set_ch(input int i, input int c, input bit d, input bit e,
                          input bit le, input logic [RES_W-1:0] r);
        ev_cyc[i]   = c;
        ev_done[i]  = d;
        ev_err[i]   = e;
        late_err[i] = le;
        res_v[i]    = r;
`ifdef EXPECTED_CHECK_EN
        exp_v[i]    = r;
`endif
    endtask

    task automatic drive_inputs(input int k);
        for (int i = 0; i < N_CH; i++) begin
            ChDone[i]  = (ev_cyc[i] >= 0) && (k >= ev_cyc[i]) && ev_done[i];
            ChError[i] = (ev_cyc[i] >= 0) && ((ev_err[i] && k >= ev_cyc[i]) ||
                                              (late_err[i] && k >= ev_cyc[i] + 2));
            ChResult[i*RES_W +: RES_W] = (k == ev_cyc[i]) ? res_v[i] : rnd_res();
`ifdef EXPECTED_CHECK_EN
            ChExpected[i*RES_W +: RES_W] = exp_v[i];
`endif
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_running"}, 64'(Running), 64'd0);
        chk({p, "_alldone"}, 64'(AllDone), 64'd0);
        chk({p, "_anyerror"}, 64'(AnyError), 64'd0);
        chk({p, "_timeout"}, 64'(Timeout), 64'd0);
        chk({p, "_outvalid"}, 64'(OutValid), 64'd0);
        chk({p, "_outchannel"}, 64'(OutChannel), 64'd0);
        chk({p, "_outresult"}, 64'(OutResult), 64'd0);
        chk({p, "_outcycles"}, 64'(OutCycles), 64'd0);
        chk({p, "_outstatus"}, 64'(OutStatus), 64'd0);
        chk({p, "_reportdone"}, 64'(ReportDone), 64'd0);
`ifdef EXPECTED_CHECK_EN
        chk({p, "_anymismatch"}, 64'(AnyMismatch), 64'd0);
`endif
    endtask

    // mode 0: ready always; 1: low 4 slots then toggling; 2: random with bounded stalls
    task automatic run_case(input int mode, input bit abort, input bit rnd_start);
        int end_c, t_all, nb, slot, lowrun, cy;
        bit all_ev, all_lat, all_dn, e_err, e_to, rdy;
        bit latched [N_CH];
        logic [1:0] st;
        logic [RES_W-1:0] r;
        bit mm_exp;
        // Reference: run ends at the earliest of all-events, first error, watchdog.
        end_c  = TO - 1;
        all_ev = 1'b1;
        t_all  = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (ev_cyc[i] < 0) all_ev = 1'b0;
            else if (ev_cyc[i] > t_all) t_all = ev_cyc[i];
        end
        if (all_ev && t_all < end_c) end_c = t_all;
        for (int i = 0; i < N_CH; i++)
            if (ev_cyc[i] >= 0 && ev_err[i] && ev_cyc[i] < end_c) end_c = ev_cyc[i];
        all_lat = 1'b1;
        all_dn  = 1'b1;
        e_err   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            latched[i] = (ev_cyc[i] >= 0) && (ev_cyc[i] <= end_c);
            if (!latched[i]) all_lat = 1'b0;
            if (!(latched[i] && ev_done[i])) all_dn = 1'b0;
            if (latched[i] && ev_err[i]) e_err = 1'b1;
        end
        e_to   = (end_c == TO - 1);
        mm_exp = 1'b0;

        Start   = 1'b1;
        ChDone  = '0;
        ChError = '0;
        tick();
        Start = 1'b0;
        chk("start_alldone_clear", 64'(AllDone), 64'd0);
        chk("start_anyerror_clear", 64'(AnyError), 64'd0);
        chk("start_timeout_clear", 64'(Timeout), 64'd0);
        chk("start_reportdone_clear", 64'(ReportDone), 64'd0);
`ifdef EXPECTED_CHECK_EN
        chk("start_anymismatch_clear", 64'(AnyMismatch), 64'd0);
`endif
        for (int k = 0; k <= end_c; k++) begin
            drive_inputs(k);
            Start = rnd_start && ($urandom_range(0, 5) == 0);
            chk("run_running", 64'(Running), 64'd1);
            chk("run_outvalid", 64'(OutValid), 64'd0);
            tick();
        end
        Start = 1'b0;
        chk("exit_running", 64'(Running), 64'd0);
        chk("exit_alldone", 64'(AllDone), 64'(all_lat && all_dn));
        chk("exit_anyerror", 64'(AnyError), 64'(e_err));
        chk("exit_timeout", 64'(Timeout), 64'(e_to));

        nb     = 0;
        slot   = 0;
        lowrun = 0;
        while (nb < N_CH && slot < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (slot >= 4) && (slot % 2 == 0);
                default: rdy = (lowrun >= 3) || ($urandom_range(0, 1) == 1);
            endcase
            lowrun   = rdy ? 0 : lowrun + 1;
            OutReady = rdy;
            Start    = rnd_start && ($urandom_range(0, 5) == 0);
            if (latched[nb]) begin
                st = ev_err[nb] ? 2'd1 : 2'd0;
                r  = res_v[nb];
                cy = ev_cyc[nb];
            end else begin
                st = 2'd2;
                r  = '0;
                cy = end_c;
            end
`ifdef EXPECTED_CHECK_EN
            if (st == 2'd0 && r != exp_v[nb]) st = 2'd3;
            chk("beat_anymismatch", 64'(AnyMismatch), 64'(mm_exp));
`endif
            chk("beat_valid", 64'(OutValid), 64'd1);
            chk("beat_channel", 64'(OutChannel), 64'(nb));
            chk("beat_result", 64'(OutResult), 64'(r));
            chk("beat_cycles", 64'(OutCycles), 64'(cy));
            chk("beat_status", 64'(OutStatus), 64'(st));
            chk("beat_reportdone", 64'(ReportDone), 64'd0);
            tick();
            slot++;
            if (rdy) begin
                if (st == 2'd3) mm_exp = 1'b1;
                nb++;
                if (abort && nb == 1) break;
            end
        end
        OutReady = 1'b0;
        Start    = 1'b0;
        if (abort) begin
            Rst = 1'b1;
            tick();
            Rst = 1'b0;
            chk_all_zero("abort");
            return;
        end
        chk("report_beat_count", 64'(nb), 64'(N_CH));
        for (int h = 0; h < 2; h++) begin
            chk("fin_reportdone", 64'(ReportDone), 64'd1);
            chk("fin_outvalid", 64'(OutValid), 64'd0);
            chk("fin_running", 64'(Running), 64'd0);
            chk("fin_alldone", 64'(AllDone), 64'(all_lat && all_dn));
            chk("fin_anyerror", 64'(AnyError), 64'(e_err));
            chk("fin_timeout", 64'(Timeout), 64'(e_to));
`ifdef EXPECTED_CHECK_EN
            chk("fin_anymismatch", 64'(AnyMismatch), 64'(mm_exp));
`endif
            tick();
        end
    endtask

    task automatic rnd_scenario();
        int kind;
        for (int i = 0; i < N_CH; i++) begin
            kind = $urandom_range(0, 3);
            set_ch(i, ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 24),
                   kind != 2, kind >= 2, (kind < 2) && ($urandom_range(0, 1) == 1), rnd_res());
`ifdef EXPECTED_CHECK_EN
            if ($urandom_range(0, 3) == 0) exp_v[i] = res_v[i] ^ 64'd1;
`endif
        end
    endtask

    initial begin
        // reset state
        Rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        Rst = 1'b0;
        tick();
        chk_all_zero("idle");

        // both channels done, ch1 first
        set_ch(0, 9, 1'b1, 1'b0, 1'b0, 64'd42);
        set_ch(1, 5, 1'b1, 1'b0, 1'b0, 64'h1234);
        run_case(0, 1'b0, 1'b0);

        // done and error together on ch0, ch1 never finishes
        set_ch(0, 3, 1'b1, 1'b1, 1'b0, 64'hABCD);
        set_ch(1, -1, 1'b0, 1'b0, 1'b0, 64'h5555);
        run_case(0, 1'b0, 1'b0);

        // watchdog expiry with nothing done
        set_ch(0, -1, 1'b0, 1'b0, 1'b0, 64'h1);
        set_ch(1, -1, 1'b0, 1'b0, 1'b0, 64'h2);
        run_case(0, 1'b0, 1'b0);

        // levels already high at Start latch with cycle 0
        set_ch(0, 0, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001);
        set_ch(1, 0, 1'b1, 1'b0, 1'b0, 64'h7);
        run_case(0, 1'b0, 1'b0);

        // stalled then toggling OutReady, late error ignored on ch1
        set_ch(0, 6, 1'b1, 1'b0, 1'b0, 64'h600D);
        set_ch(1, 2, 1'b1, 1'b0, 1'b1, 64'hF00D);
        run_case(1, 1'b0, 1'b0);

        // reset after beat 0 accepted, then a clean rerun
        set_ch(0, 9, 1'b1, 1'b0, 1'b0, 64'd42);
        set_ch(1, 5, 1'b1, 1'b0, 1'b0, 64'h1234);
        run_case(0, 1'b1, 1'b0);
        run_case(0, 1'b0, 1'b0);

`ifdef EXPECTED_CHECK_EN
        // expected-value mismatch on ch0
        set_ch(0, 2, 1'b1, 1'b0, 1'b0, 64'd42);
        set_ch(1, 4, 1'b1, 1'b0, 1'b0, 64'd7);
        exp_v[0] = 64'd43;
        run_case(0, 1'b0, 1'b0);
`endif

        // randomized runs with random backpressure and ignored Start pulses
        for (int n = 0; n < 24; n++) begin
            rnd_scenario();
            run_case(2, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/solver_run_monitor.md
Name: solver_run_monitor

Overview:
Synthesizable run monitor that generalises the single-solver Done/Error check to N_CH solver channels with parametrised result width. It measures per-channel completion cycles and latches results, flags errors and watchdog timeouts, then streams a per-channel report over a valid/ready interface. It sits in Top between the solver instances and the report/UART path, so the same Top runs one day or several days in parallel.

Parameters:
N_CH, 2, number of solver channels (1..16)
RES_W, 64, width of each channel's result
CYC_W, 32, width of the cycle counter and the reported cycle counts
TIMEOUT_CYCLES, 1000000, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Start  in  1  one-cycle pulse; starts a run from IDLE or FINISHED
ChDone  in  N_CH  per-channel done level from each solver
ChError  in  N_CH  per-channel error level from each solver
ChResult  in  N_CH*RES_W  per-channel result; channel i at [i*RES_W +: RES_W]
Running  out  1  high while in RUN
AllDone  out  1  sticky; every channel has reported done
AnyError  out  1  sticky; any channel has reported error
Timeout  out  1  sticky; watchdog expired
OutValid  out  1  report beat valid
OutReady  in  1  report beat accepted when OutValid && OutReady
OutChannel  out  max(1,$clog2(N_CH))  channel index of the beat
OutResult  out  RES_W  latched result of that channel
OutCycles  out  CYC_W  latched completion cycle of that channel
OutStatus  out  2  0 = ok, 1 = error, 2 = not finished
ReportDone  out  1  sticky; last beat accepted

Behaviour:
- Clock and reset: single clock Clk; Rst is synchronous and active-high. While Rst is sampled high, every output is 0, all per-channel latches are cleared, and the state is IDLE. Rst also aborts a run or report already in progress.
- States are IDLE, RUN, REPORT and FINISHED.
- IDLE -> RUN: Start is sampled high.
  - The cycle counter Cyc = 0 in the first RUN cycle and increments once per RUN cycle.
  - Cyc saturates at 2^CYC_W-1.
- RUN, per channel i: ChDone[i] or ChError[i] may be sampled high while channel i is not yet latched.
  - Latch done, error, ChResult slice and Cyc for channel i in that same cycle.
  - The first event wins; later changes on that channel are ignored.
  - If Done and Error arrive in the same cycle, both are latched and the status is error.
  - Error without Done still latches the result and the cycle.
- AnyError is set in the cycle after the first error latch.
- RUN exits to REPORT in the next cycle on the first of:
  - all channels latched: AllDone is set only if all channels latched done;
  - AnyError;
  - Cyc == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0: Timeout is set.
- Simultaneous exit conditions set every applicable flag.
- Running is low from the first REPORT cycle.
- REPORT: one beat per channel, indices 0..N_CH-1 in ascending order.
  - OutValid rises in the first REPORT cycle.
  - Beat fields stay stable until the handshake completes.
  - The next beat is presented in the cycle after acceptance, so back-to-back beats are possible while OutReady stays high.
  - Unlatched channels report OutStatus = 2, OutResult = 0 and OutCycles = Cyc at exit.
  - After the last beat is accepted: ReportDone = 1, OutValid = 0, state FINISHED.
- Start is ignored in RUN and REPORT.
- FINISHED: all flags and latches hold.
  - Start clears the flags and latches, drops ReportDone and enters RUN, with the same timing as IDLE -> RUN.
- ChDone and ChError are levels that are already high at Start: they latch in the first RUN cycle with cycle 0.

Optional Feature:
- Macro EXPECTED_CHECK_EN.
- With it defined:
  - Adds input ChExpected (N_CH*RES_W) and output AnyMismatch (1, sticky, reset 0).
  - In REPORT, a beat whose status is ok and whose OutResult != the expected slice reports OutStatus = 3 (mismatch).
  - AnyMismatch is set in the cycle after that beat is accepted.
  - AnyMismatch is cleared by Rst and by a restart Start.
- Without it: those ports do not exist and OutStatus never takes the value 3.

Test Plan:
1. N_CH=2. Start; ChDone[1]=1 at RUN cycle 5 with result 0x1234; ChDone[0]=1 at cycle 9 with result 42; OutReady=1.
   - Required: AllDone=1 at cycle 10.
   - Beats: (0, 42, 9, ok) then (1, 0x1234, 5, ok); then ReportDone=1.
2. Same channels 0 and 1, ChDone and ChError both high on channel 0 at cycle 3.
   - Required: AnyError=1 and AllDone=0.
   - Beats: (0, res, 3, status 1) then (1, 0, 3, status 2).
3. TIMEOUT_CYCLES=20, no channel done.
   - Required: Timeout=1 after RUN cycle 19.
   - Both beats status 2 with OutCycles=19.
4. OutReady low for 4 cycles, then toggling.
   - Required: beat 0 stays stable until accepted; no beat is lost or duplicated.
5. Rst mid-REPORT after beat 0 accepted.
   - Required: all outputs 0 next cycle.
   - A following Start runs cleanly with Cyc restarting at 0.
6. EXPECTED_CHECK_EN defined, ChExpected[0]=43, result 42.
   - Required: beat 0 has OutStatus=3; AnyMismatch=1 after acceptance.
